dmem_resp: RTL and testbench

Data-memory responder for the RV32I core: the memory-side end of the load/store interface driven by the instruction decoder's MemRead/MemWrite/func3 outputs. It accepts one request at a time over a valid/ready handshake and aligns store data into byte lanes with per-byte strobes. It sign- or zero-extends load data per func3 and returns a registered response after a programmable number of wait states. It holds the data RAM internally and replaces the core's combinational data memory when multi-cycle memory is modelled.

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/dmem_ram.sv | 28 ++
 rtl/dmem_resp.sv | 183 ++++++++++++++++++
 tb/tb_dmem_resp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store func3 codes, decoder opcodes and the
// data-memory responder FSM states.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 data RAM with per-byte write enables; synchronous write and
// synchronous read share one address and one enable.
module dmem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// RV32I data-memory responder: valid/ready request, programmable wait states,
// byte-lane stores and extended loads. DMEM_MISALIGN_CHECK_EN turns misaligned
// half/word accesses into error responses instead of truncating the address.
module dmem_resp
  import rv32i_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ld_ok_q, ld_ok_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic          cur_rd, cur_wr, access, err, misalign;
  logic [2:0]    cur_f3;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata, st_data, ram_rdata;
  logic [3:0]    st_strb;
  logic          addr_hi_unused;

  function automatic logic cmd_err(input logic rd, input logic wr, input logic [2:0] f3);
    logic bad;
    bad = (rd == wr);
    if (rd && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) bad = 1'b1;
    if (wr && !(f3 inside {F3_B, F3_H, F3_W})) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = b;
      F3_BU:   r = {24'd0, b};
      F3_H:    r = h;
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign addr_hi_unused = ^req_addr[31:AW+2];

  // In IDLE with no wait states the access uses the live request fields.
  assign cur_rd    = (state_q == IDLE) ? req_read  : rd_q;
  assign cur_wr    = (state_q == IDLE) ? req_write : wr_q;
  assign cur_f3    = (state_q == IDLE) ? req_func3 : f3_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign access = ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                    ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err = cmd_err(cur_rd, cur_wr, cur_f3) || misalign;

  always_comb begin
    st_strb = 4'b1111;
    st_data = cur_wdata;
    case (cur_f3)
      F3_B: begin
        st_strb = 4'b0001 << cur_addr[1:0];
        st_data = {4{cur_wdata[7:0]}};
      end
      F3_H: begin
        st_strb = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (access && !err),
    .we    ((access && !err && cur_wr) ? st_strb : 4'b0000),
    .addr  (cur_addr[AW+1:2]),
    .wdata (st_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    ld_ok_d   = ld_ok_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d    = req_read;
          wr_d    = req_write;
          f3_d    = req_func3;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      rsp_err_d = err;
      ld_ok_d   = !err && cur_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rsp_err_q <= 1'b0;
      ld_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
      ld_ok_q   <= ld_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  // RAM output register holds the loaded word through RESP; extension is applied after it.
  assign rsp_rdata = ld_ok_q ? load_ext(ram_rdata, f3_q, addr_q[1:0]) : 32'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two instances (0 and 3 wait states) against a byte-level
// memory model, plus directed vectors with literal expectations.
module tb_dmem_resp;

  localparam int DEP  = 64;
  localparam int MEMB = DEP * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_read = '0, req_write = '0, rsp_ready = '0;
  logic [2:0]  req_func3 [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready_a [2];
  logic        rsp_valid_a [2];
  logic        rsp_err_a   [2];
  logic [31:0] rsp_rdata_a [2];

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(DEP), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready_a[0]),
    .req_read(req_read[0]), .req_write(req_write[0]),
    .req_func3(req_func3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
  );

  dmem_resp #(.DEPTH(DEP), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready_a[1]),
    .req_read(req_read[1]), .req_write(req_write[1]),
    .req_func3(req_func3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        busy    [2] = '{1'b0, 1'b0};
  int          elapsed [2] = '{0, 0};
  logic        c_rd [2], c_wr [2];
  logic [2:0]  c_f3 [2];
  logic [31:0] c_a  [2], c_wd [2];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];
  logic [7:0]  mem [2][MEMB];

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int base(input logic [31:0] a, input logic [2:0] f3);
    int b;
    b = int'(a % MEMB);
    return b - (b % nbytes(f3));
  endfunction

  function automatic logic is_err(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (rd == wr) return 1'b1;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a % nbytes(f3) != 0) return 1'b1;
`else
    if (a === 32'hxxxxxxxx) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ld_val(input int d, input logic [2:0] f3, input logic [31:0] a);
    int b, n;
    logic [31:0] v;
    b = base(a, f3);
    n = nbytes(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mem[d][b+i]) << (8*i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        busy[d]    <= 1'b0;
        elapsed[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic go, m_rd, m_wr, e;
        logic [2:0] m_f3;
        logic [31:0] m_a, m_wd;
        go = 1'b0;
        m_rd = c_rd[d]; m_wr = c_wr[d]; m_f3 = c_f3[d]; m_a = c_a[d]; m_wd = c_wd[d];
        if (!busy[d]) begin
          if (req_valid[d]) begin
            busy[d] <= 1'b1;
            elapsed[d] <= 0;
            c_rd[d] <= req_read[d]; c_wr[d] <= req_write[d]; c_f3[d] <= req_func3[d];
            c_a[d] <= req_addr[d]; c_wd[d] <= req_wdata[d];
            m_rd = req_read[d]; m_wr = req_write[d]; m_f3 = req_func3[d];
            m_a = req_addr[d]; m_wd = req_wdata[d];
            go = (wc(d) == 0);
          end
        end else if (elapsed[d] >= wc(d)) begin
          if (rsp_ready[d]) busy[d] <= 1'b0;
        end else begin
          elapsed[d] <= elapsed[d] + 1;
          go = (elapsed[d] + 1 == wc(d));
        end
        if (go) begin
          e = is_err(m_rd, m_wr, m_f3, m_a);
          exp_er[d] <= e;
          exp_rd[d] <= (!e && m_rd) ? ld_val(d, m_f3, m_a) : 32'd0;
          if (!e && m_wr)
            for (int i = 0; i < nbytes(m_f3); i++)
              mem[d][base(m_a, m_f3) + i] <= m_wd[8*i +: 8];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        logic ev;
        ev = busy[d] && (elapsed[d] >= wc(d));
        chk($sformatf("dut%0d_req_ready", d), 32'(req_ready_a[d]), 32'(!busy[d]));
        chk($sformatf("dut%0d_rsp_valid", d), 32'(rsp_valid_a[d]), 32'(ev));
        if (ev) begin
          chk($sformatf("dut%0d_rsp_rdata", d), rsp_rdata_a[d], exp_rd[d]);
          chk($sformatf("dut%0d_rsp_err", d), 32'(rsp_err_a[d]), 32'(exp_er[d]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xact(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      input logic [31:0] xd, input logic xe, input string nm);
    int n;
    req_read[d] = rd; req_write[d] = wr; req_func3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    rsp_ready[d] = (hold == 0);
    n = 0;
    while (!req_ready_a[d] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready_a[d]) chk({nm, "_ready_timeout"}, 32'(req_ready_a[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid_a[d] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, n, wc(d) + 1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk({nm, "_rdata"}, rsp_rdata_a[d], xd);
    chk({nm, "_err"}, 32'(rsp_err_a[d]), 32'(xe));
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_func3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d_req_ready", d), 32'(req_ready_a[d]), 32'd1);
      chk($sformatf("reset%0d_rsp_valid", d), 32'(rsp_valid_a[d]), 32'd0);
      chk($sformatf("reset%0d_rsp_rdata", d), rsp_rdata_a[d], 32'd0);
      chk($sformatf("reset%0d_rsp_err", d), 32'(rsp_err_a[d]), 32'd0);
    end
    #3 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // zero wait states
    xact(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, "sw_10");
    xact(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, "lw_10");
    xact(0, 0, 1, 3'b000, 32'h13, 32'h00000080, 1, 32'h0, 0, "sb_13");
    xact(0, 1, 0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFF80, 0, "lb_13");
    xact(0, 1, 0, 3'b100, 32'h13, 32'h0, 2, 32'h00000080, 0, "lbu_13");
    xact(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0, "lw_10_b");
    xact(0, 0, 1, 3'b001, 32'h12, 32'h1234ABCD, 0, 32'h0, 0, "sh_12");
    xact(0, 1, 0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFABCD, 0, "lh_12");
    xact(0, 1, 0, 3'b101, 32'h12, 32'h0, 0, 32'h0000ABCD, 0, "lhu_12");
    xact(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABCDBEEF, 0, "lw_10_c");
`ifdef DMEM_MISALIGN_CHECK_EN
    xact(0, 1, 0, 3'b010, 32'h11, 32'h0, 0, 32'h0, 1, "lw_11");
    xact(0, 0, 1, 3'b001, 32'h13, 32'h77777777, 0, 32'h0, 1, "sh_13");
`else
    xact(0, 1, 0, 3'b010, 32'h11, 32'h0, 0, 32'hABCDBEEF, 0, "lw_11");
    xact(0, 1, 0, 3'b101, 32'h13, 32'h0, 0, 32'h0000ABCD, 0, "lhu_13");
`endif
    xact(0, 1, 0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1, "ld_f3_011");
    xact(0, 1, 1, 3'b010, 32'h10, 32'h55555555, 0, 32'h0, 1, "rd_and_wr");
    xact(0, 0, 0, 3'b010, 32'h10, 32'h55555555, 0, 32'h0, 1, "no_rd_wr");
    xact(0, 0, 1, 3'b100, 32'h10, 32'h55555555, 0, 32'h0, 1, "st_f3_100");
    xact(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hABCDBEEF, 0, "lw_after_err");
    xact(0, 0, 1, 3'b010, 32'h110, 32'hCAFEF00D, 0, 32'h0, 0, "sw_wrap");
    xact(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hCAFEF00D, 0, "lw_wrap");
    xact(0, 0, 1, 3'b000, 32'h11, 32'hFFFFFF7F, 0, 32'h0, 0, "sb_11");
    xact(0, 1, 0, 3'b000, 32'h11, 32'h0, 0, 32'h0000007F, 0, "lb_11_pos");
    xact(0, 1, 0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFCAFE, 0, "lh_12_b");
    xact(0, 1, 0, 3'b101, 32'h10, 32'h0, 0, 32'h00007F0D, 0, "lhu_10");

    // three wait states, stalled response
    xact(1, 0, 1, 3'b010, 32'h20, 32'h11111111, 5, 32'h0, 0, "w3_sw_20");
    xact(1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 32'h11111111, 0, "w3_lw_20");

    // reset while a store waits: the store must be dropped
    req_read[1] = 1'b0; req_write[1] = 1'b1; req_func3[1] = 3'b010;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h22222222; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req_ready", 32'(req_ready_a[1]), 32'd1);
    chk("rst_wait_rsp_valid", 32'(rsp_valid_a[1]), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 32'h11111111, 0, "w3_lw_after_rst");

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d want=%0d", 0, 1);
    $fatal(1);
  end

endmodule
